alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 Port: req0_a, req0_b / req1_a, req1_b  input  WIDTH  requester n operands.
REQ-006 Port: req0_op / req1_op  input  3  requester n op code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-007 Port: req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-008 Port: alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-009 Port: alu_control  output  3  op code driven to the shared ALU.
REQ-010 Port: alu_out  input  WIDTH  combinational ALU result.
REQ-011 Port: alu_zero  input  1  combinational ALU zero flag.
REQ-012 Port: rsp_valid  output  1  result register holds an undelivered result.
REQ-013 Port: rsp_id  output  1  requester index owning the held result.
REQ-014 Port: rsp_data  output  WIDTH  held result.
REQ-015 Port: rsp_zero  output  1  held zero flag.
REQ-016 Port: rsp_ready  input  1  consumer takes the held result this cycle.
REQ-017 Port: issue_cnt  output  16  count of accepted operations, saturating at 16'hFFFF.

Function
REQ-018 The FSM SHALL have two states: EMPTY (no held result) and FULL (result held).
REQ-019 The block SHALL be able to accept when state is EMPTY, or state is FULL and rsp_ready=1.
REQ-020 When able to accept, exactly one valid requester SHALL be granted; if neither is valid, none is granted.
REQ-021 Arbitration SHALL be round-robin: pointer rr names the preferred requester; the preferred requester wins if valid, else the other wins.
REQ-022 After a grant to requester n, rr SHALL become 1-n at the same edge; rr SHALL be unchanged when no grant occurs.
REQ-023 reqN_ready SHALL be combinational and high only for the granted requester in the grant cycle.
REQ-024 alu_a, alu_b, alu_control SHALL combinationally mirror the granted requester's a, b, op; with no grant they SHALL mirror requester rr's inputs.
REQ-025 On a grant, rsp_data, rsp_zero, rsp_id SHALL capture alu_out, alu_zero, winner index at the edge, and state SHALL become FULL (latency 1 cycle, request to rsp_valid).
REQ-026 In FULL with rsp_ready=1 and no grant, state SHALL become EMPTY; rsp_data/rsp_zero/rsp_id SHALL hold their values.
REQ-027 In FULL with rsp_ready=0, no grant SHALL occur and all registers SHALL hold (back-pressure).
REQ-028 Simultaneous drain and grant in FULL SHALL replace the result and stay FULL, giving one result per cycle throughput.
REQ-029 rsp_ready while EMPTY SHALL be ignored.
REQ-030 Op codes 100, 110, 111 SHALL be forwarded unmodified; the captured result is whatever the ALU returns (0, zero=1).
REQ-031 issue_cnt SHALL increment by 1 per grant and stick at 16'hFFFF.
REQ-032 rsp_valid SHALL equal (state == FULL).

Reset
REQ-033 When rst=0 at a rising edge: state EMPTY, rr=0, rsp_data=0, rsp_zero=0, rsp_id=0, issue_cnt=0.
REQ-034 During any cycle with rst=0, req0_ready and req1_ready SHALL be 0 and no grant SHALL be counted.
REQ-035 Reset mid-operation SHALL discard a held result without it being delivered.

Verification
REQ-036 Single request: req0 a=5, b=3, op=001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=2, rsp_zero=0; issue_cnt=1.
REQ-037 Contention: both valid for 4 cycles after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-038 Back-pressure: result held, rsp_ready=0 for 3 cycles with req1 valid -> req1_ready=0, rsp_data stable; rsp_ready=1 -> req1 granted same cycle, state stays FULL.
REQ-039 SLT/zero: req1 a=7, b=7, op=101 -> rsp_data=0, rsp_zero=1; a=2, b=9, op=101 -> rsp_data=1, rsp_zero=0.
REQ-040 Reset mid-flight: FULL with rsp_ready=0, assert rst=0 for one edge -> rsp_valid=0, issue_cnt=0, rr=0, readies 0 during reset.
REQ-041 Saturation: force 65537 grants -> issue_cnt=16'hFFFF and stays.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// Holds one result; a drain and a new grant may share a cycle for full throughput.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  input  logic             rsp_ready,
  output logic [15:0]      issue_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_id;
  logic [15:0]      r_issue_cnt;

  logic w_can_accept;
  logic w_gnt0;
  logic w_gnt1;
  logic w_grant;
  logic w_sel;

  // Reset gates acceptance so nothing is granted or counted while rst is low.
  assign w_can_accept = rst && ((r_state == EMPTY) || rsp_ready);
  assign w_gnt0  = w_can_accept && req0_valid && (!r_rr || !req1_valid);
  assign w_gnt1  = w_can_accept && req1_valid && (r_rr || !req0_valid);
  assign w_grant = w_gnt0 || w_gnt1;
  assign w_sel   = w_gnt0 ? 1'b0 : (w_gnt1 ? 1'b1 : r_rr);

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign alu_a       = w_sel ? req1_a  : req0_a;
  assign alu_b       = w_sel ? req1_b  : req0_b;
  assign alu_control = w_sel ? req1_op : req0_op;

  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign issue_cnt = r_issue_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_state_nxt = FULL;
      FULL: begin
        if (w_grant)        w_state_nxt = FULL;
        else if (rsp_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (r_state == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr        <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_issue_cnt <= 16'd0;
    end else if (w_grant) begin
      r_rr        <= ~w_sel;
      r_rsp_data  <= alu_out;
      r_rsp_zero  <= alu_zero;
      r_rsp_id    <= w_sel;
      if (r_issue_cnt != 16'hFFFF) r_issue_cnt <= r_issue_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// A behavioural ALU closes the loop between alu_* outputs and alu_out/alu_zero.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [2:0]       alu_control;
  logic             alu_zero;
  logic             rsp_valid, rsp_id, rsp_zero, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [15:0]      issue_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_ready(rsp_ready), .issue_cnt(issue_cnt)
  );

  always_comb begin
    case (alu_control)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b101:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, combinational checks 2ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b000;
    tick(); tick();
    #1;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);

    // Idle after reset: ALU mirrors requester 0 (rr=0).
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd11; req1_a = 32'd22;
    #1;
    check("idle_alu_a_rr0", alu_a, 32'd11);

    // Single request: 5 - 3.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b001;
    #1;
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_alu_control", {29'd0, alu_control}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("single_rsp_data", rsp_data, 32'd2);
    check("single_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    check("single_issue_cnt", {16'd0, issue_cnt}, 32'd1);
    check("idle_alu_a_rr1", alu_a, 32'd22);
    tick();
    check("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("drain_rsp_data_hold", rsp_data, 32'd2);

    // Contention from fresh reset: 10+1=11 for req0, 20-2=18 for req1.
    rst = 1'b0; tick(); rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_op = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("cont_req0_ready_%0d", k), {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont_req1_ready_%0d", k), {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("cont_rsp_id_%0d", k), {31'd0, rsp_id}, k % 2);
      check($sformatf("cont_rsp_data_%0d", k), rsp_data, (k % 2 == 0) ? 32'd11 : 32'd18);
    end
    check("cont_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("cont_issue_cnt", {16'd0, issue_cnt}, 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("cont_drained", {31'd0, rsp_valid}, 32'd0);

    // Back-pressure: hold 100+1, then req1 SLT 7<7 waits.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 3'b000;
    tick();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 3'b101;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_req1_ready_%0d", k), {31'd0, req1_ready}, 32'd0);
      check($sformatf("bp_rsp_data_%0d", k), rsp_data, 32'd101);
      tick();
    end
    check("bp_issue_cnt", {16'd0, issue_cnt}, 32'd5);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    check("slt_eq_valid", {31'd0, rsp_valid}, 32'd1);
    check("slt_eq_id", {31'd0, rsp_id}, 32'd1);
    check("slt_eq_data", rsp_data, 32'd0);
    check("slt_eq_zero", {31'd0, rsp_zero}, 32'd1);
    req1_a = 32'd2; req1_b = 32'd9;
    tick();
    check("slt_lt_data", rsp_data, 32'd1);
    check("slt_lt_zero", {31'd0, rsp_zero}, 32'd0);
    req1_op = 3'b110;
    #1;
    check("undef_op_fwd", {29'd0, alu_control}, 32'd6);
    tick();
    check("undef_op_data", rsp_data, 32'd0);
    check("undef_op_zero", {31'd0, rsp_zero}, 32'd1);

    // Reset while FULL and stalled.
    req1_valid = 1'b0; rsp_ready = 1'b0; req0_valid = 1'b1; req0_op = 3'b000;
    rst = 1'b0;
    #1;
    check("midrst_req0_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
    rst = 1'b1; rsp_ready = 1'b1; req1_valid = 1'b1;
    #1;
    check("midrst_rr0_req0", {31'd0, req0_ready}, 32'd1);
    check("midrst_rr0_req1", {31'd0, req1_ready}, 32'd0);

    // Saturation with continuous grants.
    req1_valid = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    for (int k = 0; k < 65534; k++) tick();
    check("sat_fffe", {16'd0, issue_cnt}, 32'h0000FFFE);
    tick();
    check("sat_ffff", {16'd0, issue_cnt}, 32'h0000FFFF);
    tick();
    check("sat_65537", {16'd0, issue_cnt}, 32'h0000FFFF);
    tick(); tick();
    check("sat_stays", {16'd0, issue_cnt}, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
